shift_mult_unit: RTL and testbench

//  Registered integer unit for the simple processor's ALU: W-bit multiply plus

---
 rtl/shift_mult_unit_if.sv | 23 ++
 rtl/shift_mult_unit.sv | 105 ++++++++++
 tb/tb_shift_mult_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/shift_mult_unit_if.sv
// Operation request / result bundle for shift_mult_unit.
// The master drives start/op/d1/d2; the unit returns result/valid/zero.
interface shift_mult_unit_if #(
    parameter int unsigned W = 8
) ();
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] result;
    logic         valid;
    logic         zero;

    modport master (
        output start, op, d1, d2,
        input  result, valid, zero
    );

    modport slave (
        input  start, op, d1, d2,
        output result, valid, zero
    );
endinterface

// File: rtl/shift_mult_unit.sv
// Registered W-bit multiply / shift unit for the ALU, one op per cycle, 1-cycle latency.
// Define SHIFT_ROTATE_EN to decode OP=100 as rotate-right; otherwise it is an unused code.
module shift_mult_unit #(
    parameter int unsigned W = 8
) (
    input logic               clk,
    input logic               rst_n,
    shift_mult_unit_if.slave  bus
);

    localparam int unsigned SB = $clog2(W);

    logic [W-1:0]  mul;
    logic [W-1:0]  sll;
    logic [W-1:0]  srl;
    logic [W-1:0]  sra;
    logic [SB-1:0] amt;
    logic          sat;
    logic [W-1:0]  res_d;

    logic [W-1:0]  result_q;
    logic          valid_q;
    logic          zero_q;

    // Shift-and-add array; only the low W bits are kept, so signedness is irrelevant.
    always_comb begin
        mul = '0;
        for (int i = 0; i < W; i++) begin
            if (bus.d2[i]) begin
                mul = mul + (bus.d1 << i);
            end
        end
    end

    assign amt = bus.d2[SB-1:0];
    assign sat = |(bus.d2 >> SB);

    always_comb begin
        sll = bus.d1;
        srl = bus.d1;
        sra = bus.d1;
        for (int k = 0; k < SB; k++) begin
            if (amt[k]) begin
                sll = sll << (1 << k);
                srl = srl >> (1 << k);
                sra = $signed(sra) >>> (1 << k);
            end
        end
        if (sat) begin
            sll = '0;
            srl = '0;
            sra = {W{bus.d1[W-1]}};
        end
    end

`ifdef SHIFT_ROTATE_EN
    logic [W-1:0]  ror;
    logic [SB-1:0] rot_amt;

    // Modulo keeps the rotate correct for non-power-of-two widths.
    assign rot_amt = SB'(bus.d2 % W);

    always_comb begin
        ror = bus.d1;
        for (int k = 0; k < SB; k++) begin
            if (rot_amt[k]) begin
                ror = (ror >> (1 << k)) | (ror << (W - (1 << k)));
            end
        end
    end
`endif

    always_comb begin
        res_d = '0;
        case (bus.op)
            3'b000:  res_d = mul;
            3'b001:  res_d = sll;
            3'b010:  res_d = srl;
            3'b011:  res_d = sra;
`ifdef SHIFT_ROTATE_EN
            3'b100:  res_d = ror;
`endif
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            valid_q <= bus.start;
            if (bus.start) begin
                result_q <= res_d;
                zero_q   <= (res_d == '0);
            end
        end
    end

    assign bus.result = result_q;
    assign bus.valid  = valid_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_shift_mult_unit.sv
// Self-checking bench for shift_mult_unit (W=8): directed cases plus random ops
// compared every cycle against an arithmetic reference model.
module tb_shift_mult_unit;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    shift_mult_unit_if #(.W(W)) bus ();

    shift_mult_unit #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference computed directly from the arithmetic definition of each op.
    function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
        int unsigned ua;
        int unsigned ub;
        int          sa;
        ua = a;
        ub = b;
        sa = $signed(a);
        case (op)
            3'd0: return 8'((ua * ub) % 256);
            3'd1: return (ub >= 8) ? 8'h00 : 8'(ua << ub);
            3'd2: return (ub >= 8) ? 8'h00 : 8'(ua >> ub);
            3'd3: return (ub >= 8) ? {8{a[7]}} : 8'(sa >>> ub);
`ifdef SHIFT_ROTATE_EN
            3'd4: return 8'((ua >> (ub % 8)) | (ua << (8 - (ub % 8))));
`endif
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    logic [7:0] m_result;
    logic       m_valid;
    logic       m_zero;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_result <= 8'h00;
            m_valid  <= 1'b0;
            m_zero   <= 1'b0;
        end else begin
            m_valid <= bus.start;
            if (bus.start) begin
                m_result <= model(bus.op, bus.d1, bus.d2);
                m_zero   <= (model(bus.op, bus.d1, bus.d2) == 8'h00);
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_result", 32'(bus.result), 32'(m_result));
        check("cyc_valid", 32'(bus.valid), 32'(m_valid));
        check("cyc_zero", 32'(bus.zero), 32'(m_zero));
    end

    // Issue one op, then sample #1 after the capturing edge.
    task automatic one_op(input string name, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] req);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.d1    = a;
        bus.d2    = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({name, "_res"}, 32'(bus.result), 32'(req));
        check({name, "_zero"}, 32'(bus.zero), 32'(req == 8'h00));
        check({name, "_valid"}, 32'(bus.valid), 32'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.d1    = 8'h00;
        bus.d2    = 8'h00;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check("reset_result", 32'(bus.result), 32'h0);
        check("reset_valid", 32'(bus.valid), 32'h0);
        check("reset_zero", 32'(bus.zero), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pin the reference model itself.
        check("model_mul", 32'(model(3'd0, 8'd20, 8'd20)), 32'h90);
        check("model_sra", 32'(model(3'd3, 8'h80, 8'd2)), 32'hE0);
        check("model_sll", 32'(model(3'd1, 8'h81, 8'd1)), 32'h02);

        one_op("mul_5x3", 3'd0, 8'd5, 8'd3, 8'h0F);
        one_op("mul_20x20", 3'd0, 8'd20, 8'd20, 8'h90);
        one_op("mul_zero", 3'd0, 8'h00, 8'h37, 8'h00);
        @(posedge clk);
        #1;
        check("valid_one_cycle", 32'(bus.valid), 32'd0);
        one_op("sll_81_1", 3'd1, 8'h81, 8'd1, 8'h02);
        one_op("srl_80_9", 3'd2, 8'h80, 8'd9, 8'h00);
        one_op("sra_80_2", 3'd3, 8'h80, 8'd2, 8'hE0);
        one_op("sra_80_9", 3'd3, 8'h80, 8'd9, 8'hFF);
        one_op("sra_40_0", 3'd3, 8'h40, 8'd0, 8'h40);
        one_op("unused_op", 3'd6, 8'h55, 8'h01, 8'h00);
`ifdef SHIFT_ROTATE_EN
        one_op("ror_81_1", 3'd4, 8'h81, 8'd1, 8'hC0);
        one_op("ror_81_8", 3'd4, 8'h81, 8'd8, 8'h81);
`else
        one_op("ror_off_1", 3'd4, 8'h81, 8'd1, 8'h00);
        one_op("ror_off_8", 3'd4, 8'h81, 8'd8, 8'h00);
`endif

        // Back-to-back MUL, SLL, SRA with START held high.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op = 3'd0; bus.d1 = 8'd7; bus.d2 = 8'd6;
        @(posedge clk);
        #1;
        check("b2b_mul", 32'(bus.result), 32'd42);
        check("b2b_valid0", 32'(bus.valid), 32'd1);
        bus.op = 3'd1; bus.d1 = 8'h0F; bus.d2 = 8'd4;
        @(posedge clk);
        #1;
        check("b2b_sll", 32'(bus.result), 32'hF0);
        check("b2b_valid1", 32'(bus.valid), 32'd1);
        bus.op = 3'd3; bus.d1 = 8'hC0; bus.d2 = 8'd3;
        @(posedge clk);
        #1;
        check("b2b_sra", 32'(bus.result), 32'hF8);
        check("b2b_valid2", 32'(bus.valid), 32'd1);
        bus.start = 1'b0;
        bus.op = 3'd0; bus.d1 = 8'h00; bus.d2 = 8'h00;
        @(posedge clk);
        #1;
        check("idle_valid", 32'(bus.valid), 32'd0);
        check("idle_hold", 32'(bus.result), 32'hF8);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            bus.start = ($urandom_range(0, 3) != 0);
            bus.op    = 3'($urandom_range(0, 7));
            bus.d1    = 8'($urandom);
            bus.d2    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
        end

        // Asynchronous reset mid-stream, observed without a clock edge.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op = 3'd0; bus.d1 = 8'd9; bus.d2 = 8'd9;
        @(posedge clk);
        #1;
        check("pre_reset_res", 32'(bus.result), 32'd81);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_result", 32'(bus.result), 32'h0);
        check("async_rst_valid", 32'(bus.valid), 32'h0);
        check("async_rst_zero", 32'(bus.zero), 32'h0);
        bus.start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        one_op("post_reset_mul", 3'd0, 8'd3, 8'd4, 8'h0C);
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
